button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 14 +
 rtl/debounce_channel.sv | 57 +++++
 rtl/button_conditioner.sv | 45 ++++
 tb/tb_button_conditioner.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared stopwatch constants: reset polarity, default debounce length and
// the output-mode selector used by the debounce channels.
package button_conditioner_pkg;

  localparam logic RESET_ACTIVE            = 1'b0;
  localparam int   DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int   DEBOUNCE_CNT_W_DEFAULT  = 19;

  typedef enum logic {
    OUT_LEVEL = 1'b0,
    OUT_PULSE = 1'b1
  } out_mode_e;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: two-flop synchronizer, saturating debounce counter,
// and either the debounced level or a one-cycle rising-edge pulse as output.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int        DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int        CNT_W           = DEBOUNCE_CNT_W_DEFAULT,
  parameter out_mode_e MODE            = OUT_LEVEL
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic out_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any agreement with the debounced level restarts the count, so a bounce
  // never keeps partial credit; the counter stops at CNT_LAST and cannot wrap.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q & (MODE == OUT_PULSE);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni == RESET_ACTIVE) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign out_o = (MODE == OUT_PULSE) ? pulse_q : level_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the stopwatch front panel: pause/reset buttons become one-cycle
// press pulses, adjust/select switches become clean debounced levels.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = DEBOUNCE_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic btn_pause,
  input  logic btn_reset,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic PAUSE,
  output logic RESET,
  output logic ADJ,
  output logic SEL
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .MODE(OUT_PULSE)
  ) u_pause (
    .clk_i(clk), .rst_ni(RESET_N), .raw_i(btn_pause), .out_o(PAUSE)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .MODE(OUT_PULSE)
  ) u_reset (
    .clk_i(clk), .rst_ni(RESET_N), .raw_i(btn_reset), .out_o(RESET)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .MODE(OUT_LEVEL)
  ) u_adj (
    .clk_i(clk), .rst_ni(RESET_N), .raw_i(sw_adj), .out_o(ADJ)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .MODE(OUT_LEVEL)
  ) u_sel (
    .clk_i(clk), .rst_ni(RESET_N), .raw_i(sw_sel), .out_o(SEL)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce window.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic RESET_N;
  logic btn_pause, btn_reset, sw_adj, sw_sel;
  logic PAUSE, RESET, ADJ, SEL;

  int n_tests = 0;
  int n_fail  = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .RESET_N(RESET_N),
    .btn_pause(btn_pause), .btn_reset(btn_reset),
    .sw_adj(sw_adj), .sw_sel(sw_sel),
    .PAUSE(PAUSE), .RESET(RESET), .ADJ(ADJ), .SEL(SEL)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held with every raw input pressed.
    RESET_N = 1'b0; btn_pause = 1'b1; btn_reset = 1'b1; sw_adj = 1'b1; sw_sel = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("rst_pause", PAUSE, 1'b0);
    chk("rst_reset", RESET, 1'b0);
    chk("rst_adj",   ADJ,   1'b0);
    chk("rst_sel",   SEL,   1'b0);

    // Inputs held through release count as fresh presses: change at edge 6.
    RESET_N = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rel_pause", PAUSE, 1'(k == 6));
      chk("rel_reset", RESET, 1'(k == 6));
      chk("rel_adj",   ADJ,   1'(k >= 6));
      chk("rel_sel",   SEL,   1'(k >= 6));
    end

    // Everything released: buttons give no pulse, switches drop at edge 6.
    btn_pause = 1'b0; btn_reset = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("release_pause", PAUSE, 1'b0);
      chk("release_reset", RESET, 1'b0);
      chk("release_adj",   ADJ,   1'(k < 6));
      chk("release_sel",   SEL,   1'(k < 6));
    end

    // Clean press held 20 cycles: exactly one pulse, then release.
    btn_pause = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("clean_pause", PAUSE, 1'(k == 6));
      chk("clean_reset", RESET, 1'b0);
    end
    btn_pause = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("clean_release", PAUSE, 1'b0);
    end

    // Bounce 1,0,1,0 then hold: one pulse 6 edges after the final rise.
    btn_reset = 1'b1; tick(); chk("bounce_a", RESET, 1'b0);
    btn_reset = 1'b0; tick(); chk("bounce_b", RESET, 1'b0);
    btn_reset = 1'b1; tick(); chk("bounce_c", RESET, 1'b0);
    btn_reset = 1'b0; tick(); chk("bounce_d", RESET, 1'b0);
    btn_reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("bounce_hold", RESET, 1'(k == 6));
    end
    btn_reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    // sw_adj settles high, then a 3-cycle low glitch is rejected.
    sw_adj = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("adj_set", ADJ, 1'(k >= 6));
    end
    sw_adj = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) sw_adj = 1'b1;
      tick();
      chk("adj_glitch3", ADJ, 1'b1);
    end

    // A 4-cycle low pulse is just long enough to be accepted.
    sw_adj = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) sw_adj = 1'b1;
      tick();
      chk("adj_glitch4", ADJ, 1'(k < 6 || k >= 10));
    end

    // sw_sel changed and held.
    sw_sel = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("sel_set", SEL, 1'(k >= 6));
      chk("sel_adj_hold", ADJ, 1'b1);
    end

    // Simultaneous presses pulse on the same cycle.
    btn_pause = 1'b1; btn_reset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("sim_pause", PAUSE, 1'(k == 6));
      chk("sim_reset", RESET, 1'(k == 6));
    end
    btn_pause = 1'b0; btn_reset = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("idle_adj", ADJ, 1'b0);
    chk("idle_sel", SEL, 1'b0);

    // Reset one cycle at count 2; full latency restarts from release.
    btn_pause = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("mid_pre", PAUSE, 1'b0);
    end
    RESET_N = 1'b0;
    tick();
    chk("mid_in_rst", PAUSE, 1'b0);
    RESET_N = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("mid_post", PAUSE, 1'(k == 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
